// File: rtl/multicycle_controller.sv
//----------------------------------------------------------------------------
// multicycle_controller
//
// Sequencing FSM for the multicycle RV32 core. It walks the shared datapath
// (one ALU, one unified memory port, register file, IR/OldPC/ALUOut/Data
// registers) through fetch, decode, execute, memory and writeback for each
// instruction. It stalls on the memory ready handshake, traps on
// unsupported encodings and counts retired instructions.
//
// Ports:
//   clk                    single clock, all state changes on rising edge
//   rst_n                  synchronous active-low reset
//   opcode                 IR[6:0], stable from the cycle after fetch IRWrite
//   funct3                 IR[14:12]
//   zero                   ALU zero flag, same cycle
//   mem_ready              memory completes the current access this cycle
//   PCWrite                load PC with Result
//   AdrSrc                 memory address select: 0 = PC, 1 = Result
//   MemWrite               memory write strobe
//   IRWrite                load IR and OldPC
//   RegWrite               register-file write
//   WriteRegisterData_Src  1 = write ImmExt (LUI), 0 = Result
//   Result_src             00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALU_srcA               00 = PC, 01 = OldPC, 10 = rs1
//   ALU_srcB               00 = rs2, 01 = ImmExt, 10 = constant 4
//   ALU_op                 000 ADD, 001 SUB, 010 R-type decode, 111 I-type
//   ImmSrc                 000 I, 001 S, 010 B, 011 J, 100 U
//   illegal_instr          sticky trap flag
//   instret                retired-instruction count
//----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 WriteRegisterData_Src,
    output logic [1:0]           Result_src,
    output logic [1:0]           ALU_srcA,
    output logic [1:0]           ALU_srcB,
    output logic [2:0]           ALU_op,
    output logic [2:0]           ImmSrc,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    // Supported RV32 major opcodes.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Datapath select encodings.
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_RTYPE   = 3'b010;
    localparam logic [2:0] ALU_ITYPE   = 3'b111;
    localparam logic [2:0] IMM_I       = 3'b000;
    localparam logic [2:0] IMM_S       = 3'b001;
    localparam logic [2:0] IMM_B       = 3'b010;
    localparam logic [2:0] IMM_J       = 3'b011;
    localparam logic [2:0] IMM_U       = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    state_t state;
    state_t state_next;

    // Ungated strobes; the outputs are these ANDed with rst_n so that no
    // architectural write can happen while reset is held.
    logic pc_write_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic retire;

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    // Only BEQ/BNE are implemented; other branch kinds trap.
                    OP_BRANCH:         state_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_TRAP;
                endcase
            end
            // opcode[5] separates store (0100011) from load (0000011).
            S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            // JAL redirects the PC here and writes the link in ALUWB.
            S_JAL:      state_next = S_ALUWB;
            S_LUI:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_TRAP;
        endcase
    end

    //------------------------------------------------------------------------
    // Output logic
    //------------------------------------------------------------------------
    always_comb begin
        pc_write_raw          = 1'b0;
        AdrSrc                = 1'b0;
        mem_write_raw         = 1'b0;
        ir_write_raw          = 1'b0;
        reg_write_raw         = 1'b0;
        WriteRegisterData_Src = 1'b0;
        Result_src            = RES_ALUOUT;
        ALU_srcA              = SRCA_PC;
        ALU_srcB              = SRCB_RS2;
        ALU_op                = ALU_ADD;
        illegal_instr         = 1'b0;
        unique case (state)
            S_FETCH: begin
                // PC+4 is computed and written back in the same cycle the
                // instruction word arrives.
                AdrSrc       = 1'b0;
                ALU_srcA     = SRCA_PC;
                ALU_srcB     = SRCB_FOUR;
                ALU_op       = ALU_ADD;
                Result_src   = RES_ALURES;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch/jump target OldPC+imm into ALUOut.
                ALU_srcA = SRCA_OLDPC;
                ALU_srcB = SRCB_IMM;
                ALU_op   = ALU_ADD;
            end
            S_MEMADR: begin
                ALU_srcA = SRCA_RS1;
                ALU_srcB = SRCB_IMM;
                ALU_op   = ALU_ADD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                Result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                Result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays up through the stall until the ready cycle.
                AdrSrc        = 1'b1;
                Result_src    = RES_ALUOUT;
                mem_write_raw = 1'b1;
            end
            S_EXEC_R: begin
                ALU_srcA = SRCA_RS1;
                ALU_srcB = SRCB_RS2;
                ALU_op   = ALU_RTYPE;
            end
            S_EXEC_I: begin
                ALU_srcA = SRCA_RS1;
                ALU_srcB = SRCB_IMM;
                ALU_op   = ALU_ITYPE;
            end
            S_ALUWB: begin
                Result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                // rs1-rs2 sets zero; funct3[0] inverts the sense for BNE.
                ALU_srcA     = SRCA_RS1;
                ALU_srcB     = SRCB_RS2;
                ALU_op       = ALU_SUB;
                Result_src   = RES_ALUOUT;
                pc_write_raw = zero ^ funct3[0];
            end
            S_JAL: begin
                // PC <= target held in ALUOut while the ALU forms OldPC+4.
                ALU_srcA     = SRCA_OLDPC;
                ALU_srcB     = SRCB_FOUR;
                ALU_op       = ALU_ADD;
                Result_src   = RES_ALUOUT;
                pc_write_raw = 1'b1;
            end
            S_LUI: begin
                reg_write_raw         = 1'b1;
                WriteRegisterData_Src = 1'b1;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                illegal_instr = 1'b1;
            end
        endcase
    end

    assign PCWrite  = pc_write_raw  & rst_n;
    assign MemWrite = mem_write_raw & rst_n;
    assign IRWrite  = ir_write_raw  & rst_n;
    assign RegWrite = reg_write_raw & rst_n;

    // Immediate format follows the opcode in every state except FETCH, where
    // IR still holds the previous instruction.
    always_comb begin
        ImmSrc = IMM_I;
        if (state != S_FETCH) begin
            unique case (opcode)
                OP_STORE:  ImmSrc = IMM_S;
                OP_BRANCH: ImmSrc = IMM_B;
                OP_JAL:    ImmSrc = IMM_J;
                OP_LUI:    ImmSrc = IMM_U;
                default:   ImmSrc = IMM_I;
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Retired-instruction counter
    //------------------------------------------------------------------------
    // An instruction retires on the edge leaving its last state; a store's
    // last state is MEMWRITE, left only on the ready cycle.
    assign retire = (state == S_MEMWB)  || (state == S_ALUWB) ||
                    (state == S_BRANCH) || (state == S_LUI)   ||
                    ((state == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
//----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. A behavioural model derives,
// per instruction class, the expected cycle count, strobe counts, writeback
// selects, immediate format and retire count; the bench drives random stall
// patterns and random don't-care inputs and compares the DUT against it.
// The counter width is reduced so wrap-around is reachable quickly.
//----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int IW = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Packed view of every control output while in FETCH with mem_ready=0:
    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,WRDS,Result_src,ALU_srcA,
    //  ALU_srcB,ALU_op,ImmSrc}
    localparam logic [17:0] FETCH_IDLE = {6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          zero;
    logic          mem_ready;
    logic          PCWrite;
    logic          AdrSrc;
    logic          MemWrite;
    logic          IRWrite;
    logic          RegWrite;
    logic          WriteRegisterData_Src;
    logic [1:0]    Result_src;
    logic [1:0]    ALU_srcA;
    logic [1:0]    ALU_srcB;
    logic [2:0]    ALU_op;
    logic [2:0]    ImmSrc;
    logic          illegal_instr;
    logic [IW-1:0] instret;

    int            checks   = 0;
    int            failures = 0;
    logic [IW-1:0] model_instret;

    multicycle_controller #(.INSTRET_W(IW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .opcode                (opcode),
        .funct3                (funct3),
        .zero                  (zero),
        .mem_ready             (mem_ready),
        .PCWrite               (PCWrite),
        .AdrSrc                (AdrSrc),
        .MemWrite              (MemWrite),
        .IRWrite               (IRWrite),
        .RegWrite              (RegWrite),
        .WriteRegisterData_Src (WriteRegisterData_Src),
        .Result_src            (Result_src),
        .ALU_srcA              (ALU_srcA),
        .ALU_srcB              (ALU_srcB),
        .ALU_op                (ALU_op),
        .ImmSrc                (ImmSrc),
        .illegal_instr         (illegal_instr),
        .instret               (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] out_vec();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, WriteRegisterData_Src,
                Result_src, ALU_srcA, ALU_srcB, ALU_op, ImmSrc};
    endfunction

    function automatic logic [3:0] strobes();
        return {PCWrite, IRWrite, MemWrite, RegWrite};
    endfunction

    // Immediate format expected from the opcode outside FETCH.
    function automatic logic [2:0] model_imm(input logic [6:0] op);
        case (op)
            OP_STORE:  return 3'b001;
            OP_BRANCH: return 3'b010;
            OP_JAL:    return 3'b011;
            OP_LUI:    return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    // One clock with the given mem_ready; ends 1 time unit after the edge.
    task automatic tick(input logic mr);
        mem_ready = mr;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(1'b0);
        rst_n = 1'b1;
        model_instret = '0;
    endtask

    // Runs one legal instruction with fs fetch-stall cycles and ms memory
    // stall cycles, checking it against the model.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input int fs, input int ms);
        bit   is_load  = (op == OP_LOAD);
        bit   is_store = (op == OP_STORE);
        bit   is_br    = (op == OP_BRANCH);
        bit   is_jal   = (op == OP_JAL);
        bit   is_lui   = (op == OP_LUI);
        bit   mem_op   = is_load || is_store;
        int   len      = ((is_lui || is_br) ? 3 : (is_load ? 5 : 4)) + fs + (mem_op ? ms : 0);
        int   exp_reg  = (is_store || is_br) ? 0 : 1;
        int   exp_mem  = is_store ? ms + 1 : 0;
        int   exp_pc   = 1 + ((is_br && (z ^ f3[0])) ? 1 : 0) + (is_jal ? 1 : 0);
        logic [1:0] exp_rs = is_load ? 2'b01 : 2'b00;
        int   irw_n = 0, irw_at = -1, reg_n = 0, mem_n = 0, pc_n = 0;
        opcode = op;
        funct3 = f3;
        for (int c = 0; c < len; c++) begin
            if (c < fs)                                   mem_ready = 1'b0;
            else if (c == fs)                             mem_ready = 1'b1;
            else if (mem_op && c >= fs + 3 && c < fs + 3 + ms) mem_ready = 1'b0;
            else if (mem_op && c == fs + 3 + ms)          mem_ready = 1'b1;
            else                                          mem_ready = 1'($urandom);
            zero = (is_br && c == fs + 2) ? z : 1'($urandom);
            @(negedge clk);
            if (IRWrite) begin irw_n++; irw_at = c; end
            if (PCWrite) pc_n++;
            if (RegWrite) begin
                reg_n++;
                checks++;
                if ({Result_src, WriteRegisterData_Src} !== {exp_rs, is_lui}) begin
                    failures++;
                    $display("FAIL %s wb_select: got src=%b wrds=%b want src=%b wrds=%b",
                             name, Result_src, WriteRegisterData_Src, exp_rs, is_lui);
                end
            end
            if (MemWrite) begin
                mem_n++;
                checks++;
                if (AdrSrc !== 1'b1) begin
                    failures++;
                    $display("FAIL %s store_addr: got AdrSrc=%b want 1", name, AdrSrc);
                end
            end
            if (c == fs + 1) begin
                checks++;
                if (ImmSrc !== model_imm(op)) begin
                    failures++;
                    $display("FAIL %s imm_src: got %b want %b", name, ImmSrc, model_imm(op));
                end
            end
            if (is_br && c == fs + 2) begin
                checks++;
                if (ALU_op !== 3'b001) begin
                    failures++;
                    $display("FAIL %s branch_alu_op: got %b want 001", name, ALU_op);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (irw_n !== 1 || irw_at !== fs) begin
            failures++;
            $display("FAIL %s ir_write: got count=%0d at=%0d want count=1 at=%0d",
                     name, irw_n, irw_at, fs);
        end
        checks++;
        if (reg_n !== exp_reg) begin
            failures++;
            $display("FAIL %s reg_write_count: got %0d want %0d", name, reg_n, exp_reg);
        end
        checks++;
        if (mem_n !== exp_mem) begin
            failures++;
            $display("FAIL %s mem_write_count: got %0d want %0d", name, mem_n, exp_mem);
        end
        checks++;
        if (pc_n !== exp_pc) begin
            failures++;
            $display("FAIL %s pc_write_count: got %0d want %0d", name, pc_n, exp_pc);
        end
        // After exactly len cycles the controller must be back in FETCH.
        mem_ready = 1'b0;
        #1;
        checks++;
        if (out_vec() !== FETCH_IDLE) begin
            failures++;
            $display("FAIL %s latency_%0d: got outputs %b want %b", name, len, out_vec(), FETCH_IDLE);
        end
        model_instret = model_instret + 1'b1;
        checks++;
        if (instret !== model_instret) begin
            failures++;
            $display("FAIL %s instret: got %0d want %0d", name, instret, model_instret);
        end
    endtask

    task automatic run_random(input string name);
        logic [2:0] f3 = 3'($urandom);
        logic       z  = 1'($urandom);
        int         fs = $urandom_range(0, 2);
        int         ms = $urandom_range(0, 3);
        case ($urandom_range(0, 6))
            0: run_instr(name, OP_LOAD,   3'b010, z, fs, ms);
            1: run_instr(name, OP_STORE,  3'b010, z, fs, ms);
            2: run_instr(name, OP_R,      f3,     z, fs, ms);
            3: run_instr(name, OP_I,      f3,     z, fs, ms);
            4: run_instr(name, OP_BRANCH, {2'b00, f3[0]}, z, fs, ms);
            5: run_instr(name, OP_JAL,    f3,     z, fs, ms);
            default: run_instr(name, OP_LUI, f3,  z, fs, ms);
        endcase
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        opcode    = OP_LOAD;
        funct3    = 3'b010;
        tick(1'b1);
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes: got %b want 0000", strobes());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        model_instret = '0;
        #1;
        checks++;
        if (out_vec() !== FETCH_IDLE) begin
            failures++;
            $display("FAIL reset_outputs: got %b want %b", out_vec(), FETCH_IDLE);
        end
        checks++;
        if ({illegal_instr, instret} !== {1'b0, {IW{1'b0}}}) begin
            failures++;
            $display("FAIL reset_state: got illegal=%b instret=%0d want 0 0", illegal_instr, instret);
        end
    endtask

    task automatic test_trap(input string name, input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
        tick(1'b1);
        tick(1'($urandom));
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({illegal_instr, strobes()} !== 5'b10000) begin
                failures++;
                $display("FAIL %s trap_cycle%0d: got illegal=%b strobes=%b want 1 0000",
                         name, c, illegal_instr, strobes());
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instret !== model_instret) begin
            failures++;
            $display("FAIL %s trap_instret: got %0d want %0d", name, instret, model_instret);
        end
        rst_n = 1'b0;
        tick(1'b1);
        rst_n = 1'b1;
        model_instret = '0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({illegal_instr, out_vec()} !== {1'b0, FETCH_IDLE}) begin
            failures++;
            $display("FAIL %s trap_exit: got illegal=%b out=%b want 0 %b",
                     name, illegal_instr, out_vec(), FETCH_IDLE);
        end
    endtask

    task automatic test_reset_mid_load();
        opcode = OP_LOAD;
        funct3 = 3'b010;
        tick(1'b1);   // FETCH
        tick(1'b1);   // DECODE
        tick(1'b1);   // MEMADR
        tick(1'b0);   // MEMREAD stall
        tick(1'b0);   // MEMREAD stall
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes() !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_strobes: got %b want 0000", strobes());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        model_instret = '0;
        #1;
        checks++;
        if (out_vec() !== FETCH_IDLE) begin
            failures++;
            $display("FAIL midreset_fetch: got %b want %b", out_vec(), FETCH_IDLE);
        end
        checks++;
        if (instret !== model_instret) begin
            failures++;
            $display("FAIL midreset_instret: got %0d want %0d", instret, model_instret);
        end
    endtask

    task automatic test_instret_wrap();
        apply_reset();
        for (int i = 0; i < (1 << IW) - 1; i++) run_random("wrap_fill");
        checks++;
        if (instret !== {IW{1'b1}}) begin
            failures++;
            $display("FAIL wrap_all_ones: got %0d want %0d", instret, {IW{1'b1}});
        end
        run_instr("wrap_addi", OP_I, 3'b000, 1'b0, 0, 0);
        checks++;
        if (instret !== {IW{1'b0}}) begin
            failures++;
            $display("FAIL wrap_zero: got %0d want 0", instret);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct3 = '0;
        model_instret = '0;
        test_reset();
        run_instr("lw",        OP_LOAD,   3'b010, 1'b0, 0, 0);
        run_instr("sw_stall",  OP_STORE,  3'b010, 1'b0, 0, 3);
        run_instr("beq_taken", OP_BRANCH, 3'b000, 1'b1, 0, 0);
        run_instr("bne_not",   OP_BRANCH, 3'b001, 1'b1, 0, 0);
        run_instr("jal",       OP_JAL,    3'b000, 1'b0, 0, 0);
        run_instr("lui",       OP_LUI,    3'b000, 1'b0, 0, 0);
        run_instr("lw_stall",  OP_LOAD,   3'b010, 1'b0, 2, 2);
        for (int i = 0; i < 40; i++) run_random("random");
        test_trap("trap_op0",  7'b0000000, 3'b000);
        test_trap("trap_blt",  OP_BRANCH,  3'b010);
        run_instr("after_trap", OP_R, 3'b000, 1'b0, 1, 0);
        test_reset_mid_load();
        test_instret_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32 core. It replaces the single-cycle main decoder with a per-instruction state machine that steps the shared datapath (one ALU, one unified memory port, register file, IR/OldPC/ALUOut/Data registers) through fetch, decode, execute, memory and writeback. It also stalls on a memory ready handshake, traps on unsupported encodings and counts retired instructions.

## Interface
Parameters:
- `INSTRET_W`, 32: width of retired-instruction counter.

Ports:
- `clk`  in  1  single clock, all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `opcode`  in  7  IR[6:0], stable from the cycle after the fetch IRWrite.
- `funct3`  in  3  IR[14:12].
- `zero`  in  1  ALU zero flag, same cycle.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  load PC with Result.
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = Result.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  load IR and OldPC.
- `RegWrite`  out  1  register-file write.
- `WriteRegisterData_Src`  out  1  1 = write ImmExt (LUI), 0 = Result.
- `Result_src`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALU_srcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALU_srcB`  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALU_op`  out  3  000 = ADD, 001 = SUB, 010 = R-type funct decode, 111 = I-type special.
- `ImmSrc`  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `illegal_instr`  out  1  sticky trap flag.
- `instret`  out  INSTRET_W  retired-instruction count.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, TRAP.

Outputs are combinational from the state, plus `mem_ready`, `zero` and `funct3` where noted. Any output not listed for a state is 0. `ImmSrc` is decoded from `opcode` in every state except FETCH, where it is 000.

- FETCH:
  - Fixed: AdrSrc=0, ALU_srcA=00, ALU_srcB=10, ALU_op=000, Result_src=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE: ALU_srcA=01, ALU_srcB=01, ALU_op=000 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH if funct3 ∈ {000, 001}, else TRAP
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> TRAP
- MEMADR: ALU_srcA=10, ALU_srcB=01, ALU_op=000. Next: MEMREAD if opcode[5]=0, MEMWRITE if opcode[5]=1.
- MEMREAD: AdrSrc=1, Result_src=00. Hold until mem_ready, then MEMWB.
- MEMWB: Result_src=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, Result_src=00, MemWrite=1, held until the mem_ready cycle inclusive -> FETCH.
- EXEC_R: ALU_srcA=10, ALU_srcB=00, ALU_op=010 -> ALUWB.
- EXEC_I: ALU_srcA=10, ALU_srcB=01, ALU_op=111 -> ALUWB.
- ALUWB: Result_src=00, RegWrite=1 -> FETCH.
- BRANCH:
  - ALU_srcA=10, ALU_srcB=00, ALU_op=001, Result_src=00.
  - PCWrite = zero XOR funct3[0] (BEQ/BNE).
  - -> FETCH.
- JAL: ALU_srcA=01, ALU_srcB=10, ALU_op=000, Result_src=00, PCWrite=1 -> ALUWB (writes OldPC+4).
- LUI: RegWrite=1, WriteRegisterData_Src=1 -> FETCH.
- TRAP: all strobes 0, illegal_instr=1. Absorbing; only reset exits.

instret:
- Increments by 1 on the edge leaving MEMWB, ALUWB, BRANCH or LUI, and on the edge leaving MEMWRITE with mem_ready=1.
- Wraps all-ones -> 0.
- Does not increment on entry to TRAP.

## Timing
- Reset: rst_n low at an edge forces state=FETCH, instret=0, illegal_instr=0. This applies mid-instruction as well, with no completion of the pending access.
- While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Remaining outputs after reset take their FETCH values: Result_src=10, ALU_srcB=10, all others 0.
- Latency in cycles with mem_ready=1 at every wait:
  - LUI 3, BRANCH 3
  - R-type 4, I-type 4, JAL 4, store 4
  - load 5
- Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle. Outputs are held stable throughout the stall.
- mem_ready is ignored in states other than FETCH, MEMREAD and MEMWRITE.
- Exactly one IRWrite pulse per instruction. RegWrite is at most 1 cycle per instruction, except JAL (ALUWB only).

## Test plan
- Reset then LW (0000011, funct3 010), mem_ready=1 throughout -> states F, D, MEMADR, MEMREAD, MEMWB; RegWrite high only in cycle 5 with Result_src=01; instret 0 -> 1.
- SW with mem_ready low for 3 cycles in MEMWRITE -> MemWrite high for 4 consecutive cycles with AdrSrc=1; RegWrite never high; total 7 cycles; instret +1.
- BEQ with zero=1, then BNE with zero=1 -> PCWrite=1 in the BRANCH cycle for the first and 0 for the second; ALU_op=001, ImmSrc=010.
- JAL (1101111) -> PCWrite in the JAL cycle, RegWrite in ALUWB with Result_src=00; LUI (0110111) -> RegWrite with WriteRegisterData_Src=1, ImmSrc=100, 3 cycles.
- Opcode 0000000 and branch funct3=010 -> TRAP after DECODE; illegal_instr stays 1 and all strobes 0 for 20 cycles; rst_n low for 1 edge -> FETCH, flag cleared.
- rst_n asserted during a MEMREAD stall -> next state FETCH, no RegWrite; preload instret to all-ones, retire ADDI -> instret=0.
